vga_ship_renderer: RTL and testbench
====================================

VGA_SHIP_RENDERER -- requirements
Module: vga_ship_renderer

Interface
REQ-001 SHALL have parameter NCELLS, default 4, cells per vessel, legal range 1..5.
REQ-002 SHALL have parameters COR_R, COR_G, COR_B, defaults 1, 0, 1, vessel colour.
REQ-003 SHALL have parameters ORIGEM_X and ORIGEM_Y, default 16 each, pixel origin of grid cell (1,1).
REQ-004 SHALL have parameters PASSO_X, default 62, and PASSO_Y, default 57, pixel pitch between grid cells.
REQ-005 SHALL have parameters LARGURA, default 54, and ALTURA, default 49, drawn cell size in pixels (horizontal, vertical).
REQ-006 SHALL have parameter BLINK_FRAMES, default 30, frames per blink half-period (range 1..255).
REQ-007 clk  in  1  system clock; single clock domain.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 areaAtiva  in  1  video active-area flag.
REQ-010 linha  in  10  current pixel row.
REQ-011 coluna  in  10  current pixel column.
REQ-012 frameStart  in  1  one-cycle pulse at the start of vertical blank.
REQ-013 posicoesEmbarcacao  in  8*NCELLS  per-cell grid coordinates; cell k: X=[8k+3:8k], Y=[8k+7:8k+4].
REQ-014 acertos  in  NCELLS  hit flag per cell; bit k belongs to cell k.
REQ-015 visivel  in  1  vessel display enable; sampled every cycle.
REQ-016 load  in  1  request to update positions and hits.
REQ-017 loadAck  out  1  one-cycle pulse when a pending update is applied.
REQ-018 rgb_r, rgb_g, rgb_b  out  1 each  pixel colour.

Function
REQ-019 SHALL capture posicoesEmbarcacao and acertos into shadow registers on any cycle with load=1.
REQ-020 SHALL run a two-state FSM: IDLE→PENDING on load; PENDING→IDLE on frameStart, copying shadow to active registers and pulsing loadAck in the same cycle.
REQ-021 Rule: load and frameStart together in IDLE → capture only; the update applies at the next frameStart.
REQ-022 Rule: load in PENDING → shadow overwritten, FSM stays PENDING.
REQ-023 Rule: load and frameStart together in PENDING → old shadow applied, then new data captured; FSM stays PENDING.
REQ-024 Valid coordinates are 1..8. A cell with X or Y equal to 0 or greater than 8 SHALL be disabled and never drawn.
REQ-025 SHALL compute, registered, left = ORIGEM_X+(X-1)*PASSO_X and top = ORIGEM_Y+(Y-1)*PASSO_Y, 10-bit unsigned, from active registers.
REQ-026 A pixel is inside cell k when left < coluna < left+LARGURA and top < linha < top+ALTURA (strict bounds).
REQ-027 Colour output: areaAtiva=0 or visivel=0 → 000.
REQ-028 Colour output: inside any non-hit cell → COR_R/G/B.
REQ-029 Colour output: inside a hit cell → 111 when blink phase=1, 000 when phase=0.
REQ-030 Colour output: otherwise → 000.
REQ-031 Overlap priority: hit cell over non-hit cell.
REQ-032 rgb SHALL be registered: value for (linha, coluna, areaAtiva) appears exactly 1 clk later.
REQ-033 SHALL keep an 8-bit frame counter, incremented on frameStart; at BLINK_FRAMES-1 it wraps to 0 and blink phase toggles.

Reset
REQ-034 rst=1 SHALL clear immediately: rgb 000, loadAck 0, FSM IDLE, shadow/active coordinates 0 (all cells disabled), hits 0, frame counter 0, blink phase 0.
REQ-035 rst asserted mid-PENDING SHALL discard the pending update with no loadAck pulse.

Verification
REQ-036 Reset then NCELLS=4, load cells (1,1),(2,1),(3,1),(4,1), one frameStart → loadAck 1 cycle; pixel (col 17, row 17) → 101 one cycle later; (col 16, row 17) → 000.
REQ-037 Load cell (8,8) with no frameStart → pixel (col 451, row 416) stays 000; after frameStart → 101.
REQ-038 acertos=0001, BLINK_FRAMES=2 → cell 0 pixel reads 000 for frames 0-1, 111 for frames 2-3; cell 1 constant 101.
REQ-039 Assert load and frameStart together in IDLE → no loadAck that cycle; loadAck on the next frameStart.
REQ-040 Coordinate X=0 or X=9 on a cell → that cell never drawn; visivel=0 or areaAtiva=0 → 000 everywhere.
REQ-041 Assert rst while PENDING → outputs 000 immediately; no loadAck on the following frameStart.

Source files
------------

// File: rtl/vga_ship_renderer_if.sv
// Signal bundle between a VGA timing source and the ship renderer.
// The master side drives pixel position, frame timing and vessel data; the slave side returns colour and load acknowledge.
interface vga_ship_renderer_if #(
    parameter int NCELLS = 4
);
    logic                    areaAtiva;
    logic [9:0]              linha;
    logic [9:0]              coluna;
    logic                    frameStart;
    logic [8*NCELLS-1:0]     posicoesEmbarcacao;
    logic [NCELLS-1:0]       acertos;
    logic                    visivel;
    logic                    load;
    logic                    loadAck;
    logic                    rgb_r;
    logic                    rgb_g;
    logic                    rgb_b;

    modport master (
        output areaAtiva, linha, coluna, frameStart,
        output posicoesEmbarcacao, acertos, visivel, load,
        input  loadAck, rgb_r, rgb_g, rgb_b
    );

    modport slave (
        input  areaAtiva, linha, coluna, frameStart,
        input  posicoesEmbarcacao, acertos, visivel, load,
        output loadAck, rgb_r, rgb_g, rgb_b
    );
endinterface

// File: rtl/vga_ship_renderer.sv
// Draws one vessel of NCELLS grid cells over a VGA raster, with hit cells blinking.
// Vessel updates are double-buffered and only take effect at the start of vertical blank.
module vga_ship_renderer #(
    parameter int NCELLS       = 4,
    parameter int COR_R        = 1,
    parameter int COR_G        = 0,
    parameter int COR_B        = 1,
    parameter int ORIGEM_X     = 16,
    parameter int ORIGEM_Y     = 16,
    parameter int PASSO_X      = 62,
    parameter int PASSO_Y      = 57,
    parameter int LARGURA      = 54,
    parameter int ALTURA       = 49,
    parameter int BLINK_FRAMES = 30
) (
    input logic               clk,
    input logic               rst,
    vga_ship_renderer_if.slave bus
);

    localparam logic [2:0] COR = {1'(COR_R), 1'(COR_G), 1'(COR_B)};

    typedef enum logic {
        S_IDLE,
        S_PENDING
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_apply;

    logic [8*NCELLS-1:0]   r_sh_pos;
    logic [NCELLS-1:0]     r_sh_hit;
    logic [8*NCELLS-1:0]   r_act_pos;
    logic [NCELLS-1:0]     r_act_hit;

    logic [9:0]            r_left [NCELLS];
    logic [9:0]            r_top  [NCELLS];
    logic [NCELLS-1:0]     r_en;
    logic [NCELLS-1:0]     r_hit;

    logic [7:0]            r_frame_cnt;
    logic                  r_phase;

    logic                  w_in_hit;
    logic                  w_in_plain;
    logic [2:0]            w_rgb_next;
    logic [2:0]            r_rgb;

    function automatic logic coord_ok(input logic [3:0] c);
        return (c >= 4'd1) && (c <= 4'd8);
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: defaults first so no path leaves an output unassigned and infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_apply      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.load) w_state_next = S_PENDING;
            end
            S_PENDING: begin
                if (bus.frameStart) begin
                    w_apply = 1'b1;
                    if (!bus.load) w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign bus.loadAck = w_apply;

    // A load coinciding with an apply still copies the old shadow: both sides see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_pos  <= '0;
            r_sh_hit  <= '0;
            r_act_pos <= '0;
            r_act_hit <= '0;
        end else begin
            if (bus.load) begin
                r_sh_pos <= bus.posicoesEmbarcacao;
                r_sh_hit <= bus.acertos;
            end
            if (w_apply) begin
                r_act_pos <= r_sh_pos;
                r_act_hit <= r_sh_hit;
            end
        end
    end

    // NOTE: the per-cell geometry arrays are tiny flop banks, not RAM, so they are reset like any register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NCELLS; k++) begin
                r_left[k] <= '0;
                r_top[k]  <= '0;
            end
            r_en  <= '0;
            r_hit <= '0;
        end else begin
            for (int k = 0; k < NCELLS; k++) begin
                r_left[k] <= 10'(ORIGEM_X) + (10'(r_act_pos[8*k +: 4]) - 10'd1) * 10'(PASSO_X);
                r_top[k]  <= 10'(ORIGEM_Y) + (10'(r_act_pos[8*k+4 +: 4]) - 10'd1) * 10'(PASSO_Y);
                r_en[k]   <= coord_ok(r_act_pos[8*k +: 4]) && coord_ok(r_act_pos[8*k+4 +: 4]);
                r_hit[k]  <= r_act_hit[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (bus.frameStart) begin
            if (r_frame_cnt == 8'(BLINK_FRAMES - 1)) begin
                r_frame_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    // Bounds are compared at 11 bits so left+LARGURA cannot wrap near the 10-bit limit.
    always_comb begin
        w_in_hit   = 1'b0;
        w_in_plain = 1'b0;
        for (int k = 0; k < NCELLS; k++) begin
            if (r_en[k]
                && ({1'b0, bus.coluna} > {1'b0, r_left[k]})
                && ({1'b0, bus.coluna} < ({1'b0, r_left[k]} + 11'(LARGURA)))
                && ({1'b0, bus.linha}  > {1'b0, r_top[k]})
                && ({1'b0, bus.linha}  < ({1'b0, r_top[k]} + 11'(ALTURA)))) begin
                if (r_hit[k]) w_in_hit   = 1'b1;
                else          w_in_plain = 1'b1;
            end
        end

        w_rgb_next = 3'b000;
        if (bus.areaAtiva && bus.visivel) begin
            if (w_in_hit)        w_rgb_next = r_phase ? 3'b111 : 3'b000;
            else if (w_in_plain) w_rgb_next = COR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rgb <= 3'b000;
        else     r_rgb <= w_rgb_next;
    end

    assign bus.rgb_r = r_rgb[2];
    assign bus.rgb_g = r_rgb[1];
    assign bus.rgb_b = r_rgb[0];

endmodule

// File: tb/tb_vga_ship_renderer.sv
// Self-checking bench for vga_ship_renderer: directed scenarios plus randomized loads and pixels
// checked against a cell-list model of the vessel.
module tb_vga_ship_renderer;

    localparam int N  = 4;
    localparam int BF = 2;
    localparam int OX = 16, OY = 16, PX = 62, PY = 57, W = 54, H = 49;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_ship_renderer_if #(.NCELLS(N)) bus ();

    vga_ship_renderer #(
        .NCELLS(N),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: active cells, shadow cells, pending flag, frame count since reset.
    int ax[N], ay[N];
    bit ah[N];
    int sx[N], sy[N];
    bit sh[N];
    bit pending;
    int frames;
    // Next data presented on the bus.
    int nx[N], ny[N];
    bit nh[N];

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            ax[k] = 0; ay[k] = 0; ah[k] = 0;
            sx[k] = 0; sy[k] = 0; sh[k] = 0;
        end
        pending = 0;
        frames  = 0;
    endtask

    function automatic logic [2:0] model_rgb(input int col, input int row, input bit area, input bit vis);
        bit hit_in, plain_in, phase;
        int left, top;
        hit_in = 0; plain_in = 0;
        phase = ((frames / BF) % 2) == 1;
        if (!area || !vis) return 3'b000;
        for (int k = 0; k < N; k++) begin
            if (ax[k] >= 1 && ax[k] <= 8 && ay[k] >= 1 && ay[k] <= 8) begin
                left = OX + (ax[k] - 1) * PX;
                top  = OY + (ay[k] - 1) * PY;
                if (col > left && col < left + W && row > top && row < top + H) begin
                    if (ah[k]) hit_in = 1;
                    else       plain_in = 1;
                end
            end
        end
        if (hit_in)   return phase ? 3'b111 : 3'b000;
        if (plain_in) return 3'b101;
        return 3'b000;
    endfunction

    task automatic set_cells(input int x0, input int y0, input int x1, input int y1,
                             input int x2, input int y2, input int x3, input int y3,
                             input logic [3:0] hits);
        nx[0] = x0; ny[0] = y0; nx[1] = x1; ny[1] = y1;
        nx[2] = x2; ny[2] = y2; nx[3] = x3; ny[3] = y3;
        for (int k = 0; k < N; k++) nh[k] = hits[k];
    endtask

    // One cycle of load/frameStart; loadAck checked against the model while inputs are held.
    task automatic step(input bit ld, input bit fs, input string name);
        bit exp_ack;
        bus.load       = ld;
        bus.frameStart = fs;
        for (int k = 0; k < N; k++) begin
            bus.posicoesEmbarcacao[8*k +: 8] = {4'(ny[k]), 4'(nx[k])};
            bus.acertos[k] = nh[k];
        end
        #1;
        exp_ack = pending && fs;
        n_tests++;
        if (bus.loadAck !== exp_ack) begin
            n_fail++;
            $display("FAIL %s: loadAck got %b expected %b", name, bus.loadAck, exp_ack);
        end
        if (fs && pending) begin
            for (int k = 0; k < N; k++) begin
                ax[k] = sx[k]; ay[k] = sy[k]; ah[k] = sh[k];
            end
            pending = 0;
        end
        if (fs) frames++;
        if (ld) begin
            for (int k = 0; k < N; k++) begin
                sx[k] = nx[k]; sy[k] = ny[k]; sh[k] = nh[k];
            end
            pending = 1;
        end
        @(posedge clk); #2;
        bus.load       = 1'b0;
        bus.frameStart = 1'b0;
        if (fs) begin
            @(posedge clk); #2;
        end
    endtask

    // want < 0 means expected colour comes from the model.
    task automatic check_pix(input int col, input int row, input bit area, input bit vis,
                             input int want, input string name);
        logic [2:0] exp, got;
        bus.coluna    = 10'(col);
        bus.linha     = 10'(row);
        bus.areaAtiva = area;
        bus.visivel   = vis;
        exp = (want >= 0) ? 3'(want) : model_rgb(col, row, area, vis);
        @(posedge clk); #2;
        got = {bus.rgb_r, bus.rgb_g, bus.rgb_b};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: rgb at (col %0d,row %0d) got %b expected %b", name, col, row, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.frameStart = 1'b1;
        #1;
        n_tests++;
        if ({bus.rgb_r, bus.rgb_g, bus.rgb_b} !== 3'b000 || bus.loadAck !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: rgb %b loadAck %b expected 000/0",
                     {bus.rgb_r, bus.rgb_g, bus.rgb_b}, bus.loadAck);
        end
        @(posedge clk); #2;
        bus.frameStart = 1'b0;
        rst = 1'b0;
        model_reset();
        set_cells(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        step(0, 1, "reset_no_ack");
        check_pix(17, 17, 1, 1, 0, "reset_cells_disabled");
    endtask

    task automatic test_basic();
        set_cells(1, 1, 2, 1, 3, 1, 4, 1, 4'b0000);
        step(1, 0, "basic_load");
        check_pix(17, 17, 1, 1, 0, "basic_before_apply");
        step(0, 1, "basic_apply_ack");
        step(0, 0, "basic_ack_one_cycle");
        check_pix(17, 17, 1, 1, 5, "basic_inside");
        check_pix(16, 17, 1, 1, 0, "basic_left_edge");
        check_pix(17, 16, 1, 1, 0, "basic_top_edge");
        check_pix(69, 64, 1, 1, 5, "basic_far_corner_in");
        check_pix(70, 30, 1, 1, 0, "basic_right_edge");
        check_pix(30, 65, 1, 1, 0, "basic_bottom_edge");
        check_pix(79, 17, 1, 1, 5, "basic_cell1");
        check_pix(74, 30, 1, 1, 0, "basic_gap");
    endtask

    task automatic test_no_frame();
        set_cells(8, 8, 2, 1, 3, 1, 4, 1, 4'b0000);
        step(1, 0, "far_load");
        step(0, 0, "far_idle");
        check_pix(451, 416, 1, 1, 0, "far_before_frame");
        step(0, 1, "far_apply_ack");
        check_pix(451, 416, 1, 1, 5, "far_after_frame");
        check_pix(17, 17, 1, 1, 0, "far_old_cell_gone");
    endtask

    task automatic test_blink();
        set_cells(1, 1, 2, 1, 0, 0, 0, 0, 4'b0001);
        step(1, 0, "blink_load");
        step(0, 1, "blink_apply");
        for (int f = 0; f < 6; f++) begin
            check_pix(17, 17, 1, 1, -1, "blink_hit_cell");
            check_pix(79, 17, 1, 1, 5, "blink_plain_cell");
            step(0, 1, "blink_frame");
        end
        set_cells(3, 3, 3, 3, 0, 0, 0, 0, 4'b0001);
        step(1, 0, "overlap_load");
        step(0, 1, "overlap_apply");
        for (int f = 0; f < 4; f++) begin
            check_pix(150, 140, 1, 1, -1, "overlap_hit_priority");
            step(0, 1, "overlap_frame");
        end
    endtask

    task automatic test_simultaneous();
        set_cells(5, 5, 0, 0, 0, 0, 0, 0, 4'b0000);
        step(1, 1, "simul_idle_no_ack");
        check_pix(OX + 4*PX + 5, OY + 4*PY + 5, 1, 1, 0, "simul_not_applied");
        step(0, 1, "simul_next_frame_ack");
        check_pix(OX + 4*PX + 5, OY + 4*PY + 5, 1, 1, 5, "simul_applied");
        set_cells(1, 1, 0, 0, 0, 0, 0, 0, 4'b0000);
        step(1, 0, "pend_load_a");
        set_cells(2, 2, 0, 0, 0, 0, 0, 0, 4'b0000);
        step(1, 0, "pend_overwrite_b");
        set_cells(3, 3, 0, 0, 0, 0, 0, 0, 4'b0000);
        step(1, 1, "pend_apply_b_capture_c");
        check_pix(OX + PX + 5, OY + PY + 5, 1, 1, 5, "pend_b_active");
        check_pix(OX + 5, OY + 5, 1, 1, 0, "pend_a_discarded");
        step(0, 1, "pend_apply_c");
        check_pix(OX + 2*PX + 5, OY + 2*PY + 5, 1, 1, 5, "pend_c_active");
        step(0, 1, "pend_idle_no_ack");
    endtask

    task automatic test_invalid();
        set_cells(0, 1, 9, 1, 2, 0, 2, 9, 4'b0000);
        step(1, 0, "inv_load");
        step(0, 1, "inv_apply");
        check_pix(OX - PX + 5, 20, 1, 1, 0, "inv_x0");
        check_pix(OX + 8*PX + 5, 20, 1, 1, 0, "inv_x9");
        check_pix(OX + PX + 5, OY + 8*PY + 5, 1, 1, 0, "inv_y9");
        check_pix(OX + 5, OY + 5, 1, 1, 0, "inv_origin_empty");
        set_cells(1, 1, 0, 0, 0, 0, 0, 0, 4'b0000);
        step(1, 0, "vis_load");
        step(0, 1, "vis_apply");
        check_pix(17, 17, 1, 1, 5, "vis_on");
        check_pix(17, 17, 1, 0, 0, "vis_off");
        check_pix(17, 17, 0, 1, 0, "area_off");
    endtask

    task automatic test_reset_pending();
        set_cells(1, 1, 0, 0, 0, 0, 0, 0, 4'b0000);
        step(1, 0, "rstp_load");
        step(0, 1, "rstp_apply");
        set_cells(6, 6, 0, 0, 0, 0, 0, 0, 4'b0000);
        step(1, 0, "rstp_pending_load");
        check_pix(17, 17, 1, 1, 5, "rstp_before_reset");
        rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.rgb_r, bus.rgb_g, bus.rgb_b} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstp_immediate: rgb got %b expected 000", {bus.rgb_r, bus.rgb_g, bus.rgb_b});
        end
        @(posedge clk); #2;
        rst = 1'b0;
        model_reset();
        step(0, 1, "rstp_no_ack_after");
        check_pix(OX + 5*PX + 5, OY + 5*PY + 5, 1, 1, 0, "rstp_pending_discarded");
        check_pix(17, 17, 1, 1, 0, "rstp_active_cleared");
    endtask

    task automatic test_random();
        int k, col, row;
        bit area, vis;
        for (int it = 0; it < 40; it++) begin
            for (int c = 0; c < N; c++) begin
                nx[c] = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 8);
                ny[c] = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 8);
                nh[c] = $urandom_range(0, 3) == 0;
            end
            step($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, "rand_step");
            for (int p = 0; p < 4; p++) begin
                k = $urandom_range(0, N - 1);
                if (ax[k] >= 1 && ax[k] <= 8 && ay[k] >= 1 && ay[k] <= 8) begin
                    col = OX + (ax[k] - 1) * PX + $urandom_range(0, W + 1);
                    row = OY + (ay[k] - 1) * PY + $urandom_range(0, H + 1);
                end else begin
                    col = $urandom_range(0, 639);
                    row = $urandom_range(0, 479);
                end
                area = $urandom_range(0, 7) != 0;
                vis  = $urandom_range(0, 7) != 0;
                check_pix(col, row, area, vis, -1, "rand_pixel");
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.areaAtiva = 1'b0;
        bus.linha = '0;
        bus.coluna = '0;
        bus.frameStart = 1'b0;
        bus.posicoesEmbarcacao = '0;
        bus.acertos = '0;
        bus.visivel = 1'b0;
        bus.load = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        test_reset();
        test_basic();
        test_no_frame();
        test_reset();
        test_blink();
        test_simultaneous();
        test_invalid();
        test_reset_pending();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
